// File: rtl/vec_op_pack_if.sv
// Stream bundle for vec_op_pack: scalar element input plus packed-vector
// output with its valid/ready handshake.
interface vec_op_pack_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_LEN    = 4
);
  logic                          in_vld;
  logic [DATA_WIDTH-1:0]         x_in;
  logic [VEC_LEN*DATA_WIDTH-1:0] vec_out;
  logic                          vec_vld;
  logic                          vec_rdy;

  // Producer of elements and consumer of vectors.
  modport master (
    output in_vld, x_in, vec_rdy,
    input  vec_out, vec_vld
  );

  // The packer itself.
  modport slave (
    input  in_vld, x_in, vec_rdy,
    output vec_out, vec_vld
  );
endinterface

// File: rtl/vec_op_pack.sv
// vec_op_pack: collects VEC_LEN scalar CORDIC results into one packed vector.
// Double-buffered: a fill register gathers elements while the output register
// is held for the consumer. Elements that cannot be stored are dropped and
// flagged through the sticky overflow bit.
// Optional macro VEC_OP_PACK_DROP_CNT_EN adds an 8-bit saturating drop counter.
module vec_op_pack #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_LEN    = 4,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  vec_op_pack_if.slave         bus,
  input  logic                 flush,
  output logic [IDX_WIDTH-1:0] elem_idx,
  output logic                 overflow,
  input  logic                 clr_ovf
`ifdef VEC_OP_PACK_DROP_CNT_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);

  localparam int unsigned VEC_W = VEC_LEN * DATA_WIDTH;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [VEC_W-1:0]     fill_q, fill_d;
  logic [VEC_W-1:0]     vec_out_q, vec_out_d;
  logic                 vec_vld_q, vec_vld_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic                 drop;
  logic                 load_out;
  logic                 handshake;
  logic                 out_free;

  assign handshake = vec_vld_q & bus.vec_rdy;
  assign out_free  = ~vec_vld_q | bus.vec_rdy;

  // Next-state: element capture, hold/transfer of the completed vector, drops.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    vec_out_d = vec_out_q;
    idx_d     = idx_q;
    drop      = 1'b0;
    load_out  = 1'b0;
    case (state_q)
      FILL: begin
        if (flush) begin
          idx_d = '0;
        end else if (bus.in_vld) begin
          for (int unsigned k = 0; k < VEC_LEN; k++) begin
            if (idx_q == IDX_WIDTH'(k)) begin
              fill_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.x_in;
            end
          end
          if (idx_q == IDX_WIDTH'(VEC_LEN - 1)) begin
            idx_d = '0;
            if (out_free) begin
              load_out = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = FILL;
          idx_d   = '0;
        end else begin
          drop = bus.in_vld;
          if (handshake) begin
            load_out = 1'b1;
            state_d  = FILL;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    if (load_out) begin
      vec_out_d = fill_d;
    end
    vec_vld_d = load_out | (vec_vld_q & ~bus.vec_rdy);
    ovf_d     = drop | (ovf_q & ~clr_ovf);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= FILL;
      fill_q    <= '0;
      vec_out_q <= '0;
      vec_vld_q <= 1'b0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      vec_out_q <= vec_out_d;
      vec_vld_q <= vec_vld_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.vec_out = vec_out_q;
  assign bus.vec_vld = vec_vld_q;
  assign elem_idx    = idx_q;
  assign overflow    = ovf_q;

`ifdef VEC_OP_PACK_DROP_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating drop counter; a drop coinciding with clear restarts at one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_ovf) begin
      cnt_d = drop ? CNT_W'(1) : '0;
    end else if (drop && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_cnt = cnt_q;
`endif

endmodule
